// File: rtl/conv_pim_pkg.sv
// Shared definitions for the bit-sliced PIM convolution engine.
//   clogb2      : ceil(log2(v)), never less than 1, for sizing counters and selects
//   NS, N, OUT_W: derived sizes for the default configuration (KSIZE=5, DATA_W=6, SLICE_W=3)
//   state_e     : engine FSM states
package conv_pim_pkg;

  function automatic int unsigned clogb2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(v)) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int unsigned KSIZE_DEF   = 5;
  localparam int unsigned DATA_W_DEF  = 6;
  localparam int unsigned SLICE_W_DEF = 3;
  localparam int unsigned NS    = DATA_W_DEF / SLICE_W_DEF;
  localparam int unsigned N     = KSIZE_DEF * KSIZE_DEF;
  localparam int unsigned OUT_W = 2 * DATA_W_DEF + $clog2(N);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/conv_kxk_sliced_pim_if.sv
// Window/kernel/result bus between the window buffer, the engine and the output writer.
//   master: drives k_load, kernel, in_valid, in_data, out_ready
//   slave : the engine; drives in_ready, out_valid, out_data, adc_sat
interface conv_kxk_sliced_pim_if #(
  parameter int unsigned N      = 25,
  parameter int unsigned DATA_W = 6,
  parameter int unsigned OUT_W  = 17
);
  logic                  k_load;
  logic [N*DATA_W-1:0]   kernel;
  logic                  in_valid;
  logic                  in_ready;
  logic [N*DATA_W-1:0]   in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;
  logic                  adc_sat;

  modport master (
    output k_load, kernel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, adc_sat
  );

  modport slave (
    input  k_load, kernel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, adc_sat
  );
endinterface

// File: rtl/pim_slice_mac.sv
// One PIM slice-MAC: registered dot product of N SLICE_W-bit input slices with N weight
// slices, clamped to the ADC full scale 2^ADC_P-1.
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : capture a new partial this cycle
//   in_slice_i   : packed input slices, element 0 in LSBs
//   w_slice_i    : packed weight slices, element 0 in LSBs
//   psum_o       : clamped partial (registered)
//   sat_o        : the registered partial was clamped
module pim_slice_mac #(
  parameter int unsigned N       = 25,
  parameter int unsigned SLICE_W = 3,
  parameter int unsigned ADC_P   = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [N*SLICE_W-1:0] in_slice_i,
  input  logic [N*SLICE_W-1:0] w_slice_i,
  output logic [ADC_P-1:0]     psum_o,
  output logic                 sat_o
);
  localparam int unsigned RawW = 2 * SLICE_W + $clog2(N);
  // Compare in a width that holds both the raw sum and the full-scale code.
  localparam int unsigned CmpW = (RawW > ADC_P) ? RawW : ADC_P;
  localparam logic [CmpW-1:0] FullScale = CmpW'((64'd1 << ADC_P) - 64'd1);

  logic [CmpW-1:0]  raw;
  logic [ADC_P-1:0] psum_q;
  logic             sat_q;

  always_comb begin
    raw = '0;
    for (int unsigned e = 0; e < N; e++) begin
      raw = raw + CmpW'(in_slice_i[e*SLICE_W +: SLICE_W]) * CmpW'(w_slice_i[e*SLICE_W +: SLICE_W]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psum_q <= '0;
      sat_q  <= 1'b0;
    end else if (en_i) begin
      if (raw > FullScale) begin
        psum_q <= ADC_P'(FullScale);
        sat_q  <= 1'b1;
      end else begin
        psum_q <= ADC_P'(raw);
        sat_q  <= 1'b0;
      end
    end
  end

  assign psum_o = psum_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/conv_kxk_sliced_pim.sv
// Bit-sliced PIM convolution over one KSIZE x KSIZE window. A single slice-MAC is reused for
// every (input-slice, weight-slice) pair; each clamped partial is shifted by its slice
// significance and accumulated. One window per NS*NS+3 cycles.
//   clk_i, rst_i : clock, synchronous active-high reset (aborts any window in flight)
//   bus          : slave side of conv_kxk_sliced_pim_if (kernel load, window in, result out)
module conv_kxk_sliced_pim
  import conv_pim_pkg::*;
#(
  parameter int unsigned KSIZE   = 5,
  parameter int unsigned DATA_W  = 6,
  parameter int unsigned SLICE_W = 3,
  parameter int unsigned ADC_P   = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  conv_kxk_sliced_pim_if.slave  bus
);
  localparam int unsigned NElem  = KSIZE * KSIZE;
  localparam int unsigned NSlc   = DATA_W / SLICE_W;
  localparam int unsigned Passes = NSlc * NSlc;
  localparam int unsigned OutW   = 2 * DATA_W + $clog2(NElem);
  localparam int unsigned PassW  = clogb2(Passes + 1);
  localparam int unsigned IdxW   = clogb2(NSlc);
  localparam int unsigned ShW    = clogb2(2 * SLICE_W * (NSlc - 1) + 1);

  state_e                    state_q;
  logic [PassW-1:0]          pass_q;
  logic [IdxW-1:0]           isel_q;
  logic [IdxW-1:0]           wsel_q;
  logic [ShW-1:0]            shift_q;
  logic                      acc_en_q;
  logic [OutW-1:0]           acc_q;
  logic                      sat_q;
  logic                      out_valid_q;
  logic [NElem*DATA_W-1:0]   win_q;
  logic [NElem*DATA_W-1:0]   wbank_q;

  logic [NElem*SLICE_W-1:0]  in_slice;
  logic [NElem*SLICE_W-1:0]  w_slice;
  logic                      issue;
  logic [ADC_P-1:0]          mac_psum;
  logic                      mac_sat;

  // Slice-select muxes: pick slice isel of every window element and slice wsel of every weight.
  always_comb begin
    in_slice = '0;
    w_slice  = '0;
    for (int unsigned e = 0; e < NElem; e++) begin
      in_slice[e*SLICE_W +: SLICE_W] = win_q[e*DATA_W + 32'(isel_q)*SLICE_W +: SLICE_W];
      w_slice[e*SLICE_W +: SLICE_W]  = wbank_q[e*DATA_W + 32'(wsel_q)*SLICE_W +: SLICE_W];
    end
  end

  assign issue = (state_q == StRun) && (pass_q < PassW'(Passes));

  pim_slice_mac #(
    .N       (NElem),
    .SLICE_W (SLICE_W),
    .ADC_P   (ADC_P)
  ) u_mac (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (issue),
    .in_slice_i (in_slice),
    .w_slice_i  (w_slice),
    .psum_o     (mac_psum),
    .sat_o      (mac_sat)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pass_q      <= '0;
      isel_q      <= '0;
      wsel_q      <= '0;
      shift_q     <= '0;
      acc_en_q    <= 1'b0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      win_q       <= '0;
      wbank_q     <= '0;
    end else begin
      // The partial issued this cycle lands in the MAC register; accumulate it next cycle.
      acc_en_q <= issue;
      unique case (state_q)
        StIdle: begin
          if (bus.k_load) begin
            wbank_q <= bus.kernel;
          end else if (bus.in_valid) begin
            win_q   <= bus.in_data;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            pass_q  <= '0;
            isel_q  <= '0;
            wsel_q  <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          if (issue) begin
            pass_q  <= pass_q + PassW'(1);
            shift_q <= ShW'(SLICE_W * (32'(isel_q) + 32'(wsel_q)));
            if (isel_q == IdxW'(NSlc - 1)) begin
              isel_q <= '0;
              wsel_q <= wsel_q + IdxW'(1);
            end else begin
              isel_q <= isel_q + IdxW'(1);
            end
          end
          if (acc_en_q) begin
            acc_q <= acc_q + (OutW'(mac_psum) << shift_q);
            sat_q <= sat_q | mac_sat;
          end
          // All passes issued and the final partial is being accumulated now.
          if (pass_q == PassW'(Passes)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (bus.out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= StIdle;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !bus.k_load;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = (state_q == StDone) ? acc_q : '0;
  assign bus.adc_sat   = (state_q == StDone) && sat_q;

endmodule

// File: tb/tb_conv_kxk_sliced_pim.sv
module tb_conv_kxk_sliced_pim;
  localparam int unsigned NE = 25;
  localparam int unsigned DW = 6;
  localparam int unsigned OW = 17;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_kxk_sliced_pim_if #(.N(NE), .DATA_W(DW), .OUT_W(OW)) bus ();
  conv_kxk_sliced_pim_if #(.N(NE), .DATA_W(DW), .OUT_W(OW)) bus_w ();

  // Wide-ADC instance runs in lockstep on the same stimulus.
  assign bus_w.k_load    = bus.k_load;
  assign bus_w.kernel    = bus.kernel;
  assign bus_w.in_valid  = bus.in_valid;
  assign bus_w.in_data   = bus.in_data;
  assign bus_w.out_ready = bus.out_ready;

  conv_kxk_sliced_pim dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  conv_kxk_sliced_pim #(.ADC_P(11)) dut_w (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_w)
  );

  int tests = 0;
  int fails = 0;

  function automatic logic [NE*DW-1:0] rep(input logic [DW-1:0] v);
    logic [NE*DW-1:0] r;
    for (int e = 0; e < NE; e++) r[e*DW +: DW] = v;
    return r;
  endfunction

  // Stimulus helpers (no comparisons); all start at a negedge.
  task automatic load_kernel(input logic [DW-1:0] v);
    bus.kernel = rep(v);
    bus.k_load = 1'b1;
    @(negedge clk);
    bus.k_load = 1'b0;
  endtask

  task automatic start_window(input logic [DW-1:0] v);
    bus.in_data  = rep(v);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 40);
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
    tests++; if (bus.out_data !== 17'd0) begin fails++; $display("FAIL reset_out_data got %0d want 0", bus.out_data); end
    tests++; if (bus.adc_sat !== 1'b0) begin fails++; $display("FAIL reset_adc_sat got %0b want 0", bus.adc_sat); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
  endtask

  task automatic test_ones();
    int n;
    load_kernel(6'd1);
    start_window(6'd1);
    wait_result(n);
    tests++; if (n !== 6) begin fails++; $display("FAIL ones_latency got %0d want 6", n); end
    tests++; if (bus.out_data !== 17'd25) begin fails++; $display("FAIL ones_data got %0d want 25", bus.out_data); end
    tests++; if (bus.adc_sat !== 1'b0) begin fails++; $display("FAIL ones_sat got %0b want 0", bus.adc_sat); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL ones_in_ready_done got %0b want 0", bus.in_ready); end
    handshake();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL ones_valid_drop got %0b want 0", bus.out_valid); end
    tests++; if (bus.out_data !== 17'd0) begin fails++; $display("FAIL ones_data_idle got %0d want 0", bus.out_data); end
  endtask

  task automatic test_high_slices();
    int n;
    load_kernel(6'd8);
    start_window(6'd8);
    wait_result(n);
    tests++; if (bus.out_data !== 17'd1600) begin fails++; $display("FAIL hh_data got %0d want 1600", bus.out_data); end
    tests++; if (bus.adc_sat !== 1'b0) begin fails++; $display("FAIL hh_sat got %0b want 0", bus.adc_sat); end
    handshake();
  endtask

  task automatic test_saturation();
    int n;
    load_kernel(6'd63);
    start_window(6'd63);
    wait_result(n);
    tests++; if (bus.out_data !== 17'd5103) begin fails++; $display("FAIL sat_data got %0d want 5103", bus.out_data); end
    tests++; if (bus.adc_sat !== 1'b1) begin fails++; $display("FAIL sat_flag got %0b want 1", bus.adc_sat); end
    tests++; if (bus_w.out_valid !== 1'b1) begin fails++; $display("FAIL wide_valid got %0b want 1", bus_w.out_valid); end
    tests++; if (bus_w.out_data !== 17'd99225) begin fails++; $display("FAIL wide_data got %0d want 99225", bus_w.out_data); end
    tests++; if (bus_w.adc_sat !== 1'b0) begin fails++; $display("FAIL wide_sat got %0b want 0", bus_w.adc_sat); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int n;
    load_kernel(6'd1);
    start_window(6'd1);
    wait_result(n);
    bus.in_data  = rep(6'd2);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid c%0d got %0b want 1", c, bus.out_valid); end
      tests++; if (bus.out_data !== 17'd25) begin fails++; $display("FAIL hold_data c%0d got %0d want 25", c, bus.out_data); end
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready c%0d got %0b want 0", c, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_valid_drop got %0b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %0b want 1", bus.in_ready); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(n);
    tests++; if (n !== 6) begin fails++; $display("FAIL b2b_latency got %0d want 6", n); end
    tests++; if (bus.out_data !== 17'd50) begin fails++; $display("FAIL b2b_data got %0d want 50", bus.out_data); end
    handshake();
  endtask

  task automatic test_kload();
    int n;
    bus.kernel   = rep(6'd2);
    bus.k_load   = 1'b1;
    bus.in_data  = rep(6'd1);
    bus.in_valid = 1'b1;
    #1;
    tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL kload_in_ready got %0b want 0", bus.in_ready); end
    @(negedge clk);
    bus.k_load = 1'b0;
    #1;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL kload_next_ready got %0b want 1", bus.in_ready); end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    wait_result(n);
    tests++; if (n !== 6) begin fails++; $display("FAIL kload_latency got %0d want 6", n); end
    tests++; if (bus.out_data !== 17'd50) begin fails++; $display("FAIL kload_new_kernel got %0d want 50", bus.out_data); end
    handshake();
    // Load attempt while running must be ignored.
    start_window(6'd1);
    bus.kernel = rep(6'd3);
    bus.k_load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.k_load = 1'b0;
    wait_result(n);
    tests++; if (n + 2 !== 6) begin fails++; $display("FAIL kload_run_latency got %0d want 6", n + 2); end
    tests++; if (bus.out_data !== 17'd50) begin fails++; $display("FAIL kload_run_ignored got %0d want 50", bus.out_data); end
    handshake();
    start_window(6'd1);
    wait_result(n);
    tests++; if (bus.out_data !== 17'd50) begin fails++; $display("FAIL kload_bank_kept got %0d want 50", bus.out_data); end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int n;
    logic seen;
    load_kernel(6'd1);
    start_window(6'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %0b want 0", bus.out_valid); end
    tests++; if (bus.out_data !== 17'd0) begin fails++; $display("FAIL rstmid_data got %0d want 0", bus.out_data); end
    tests++; if (bus.adc_sat !== 1'b0) begin fails++; $display("FAIL rstmid_sat got %0b want 0", bus.adc_sat); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_in_ready got %0b want 1", bus.in_ready); end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | bus.out_valid;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstmid_no_pulse got %0b want 0", seen); end
    start_window(6'd1);
    wait_result(n);
    tests++; if (n !== 6) begin fails++; $display("FAIL rstmid_latency got %0d want 6", n); end
    tests++; if (bus.out_data !== 17'd0) begin fails++; $display("FAIL rstmid_bank_cleared got %0d want 0", bus.out_data); end
    handshake();
  endtask

  initial begin
    rst           = 1'b1;
    bus.k_load    = 1'b0;
    bus.kernel    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_ones();
    test_high_slices();
    test_saturation();
    test_back_to_back();
    test_kload();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
